serial_bit_tx: RTL and testbench
================================

# serial_bit_tx

Parallel-to-serial bit transmitter that drives a data bit plus a one-clock qualifying strobe. Its outputs feed the data and enable inputs of enable-gated capture flops (d + en) downstream. A parallel word is accepted through a valid/ready handshake, then shifted out MSB-first at a fixed number of clocks per bit. A one-cycle completion pulse marks the end of each word.

## Interface
- DBIT, 8: data word width; must be ≥ 1.
- CLK_PER_BIT, 4: clocks per serial bit; must be ≥ 1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- start  in  1  request to transmit `din`; sampled only when `ready` = 1.
- din  in  DBIT  parallel word to send; captured on the accepting edge.
- ready  out  1  high when idle and able to accept `start`.
- sout  out  1  serial data bit to the downstream flop's d input.
- sout_en  out  1  one-clock strobe; downstream captures `sout` on the edge where `sout_en` = 1.
- done_tick  out  1  one-clock pulse on the final cycle of a word.

## Operation
- Storage:
  - state register (IDLE, DATA, and PARITY when configured);
  - shift register, DBIT bits;
  - cycle counter, $clog2(CLK_PER_BIT) bits, minimum 1;
  - bit counter, $clog2(DBIT+1) bits.
- Structure:
  - registers update in a single clocked block with async reset;
  - next-state logic is a separate combinational block;
  - outputs are decoded from registered state only (Moore): no combinational path from `start` or `din` to any output.
- IDLE:
  - `ready` = 1, `sout` = 0, `sout_en` = 0.
  - On `start` = 1: load shift register with `din`, clear both counters, go to DATA.
- DATA:
  - `sout` = shift register MSB.
  - Cycle counter increments every clock; `sout_en` = 1 when cycle counter = CLK_PER_BIT−1.
  - On that cycle: cycle counter wraps to 0, shift register shifts left by one (0 fills the LSB), bit counter increments.
  - When the bit counter reaches DBIT−1 and the cycle counter wraps: go to IDLE, or to PARITY if configured.
- `start` while not IDLE: ignored; `din` changes while busy: no effect.
- `done_tick` = 1 on the cycle the final bit's `sout_en` is high, i.e. the last busy cycle.
- Reset mid-word: abort immediately to IDLE; no `done_tick`, no further `sout_en`.

## Timing
- Reset values: `ready` = 1, `sout` = 0, `sout_en` = 0, `done_tick` = 0; state IDLE; all counters 0.
- Start accepted at edge E0. On the cycles after it:
  - cycles 1..CLK_PER_BIT: `sout` = din[DBIT−1];
  - first `sout_en` in cycle CLK_PER_BIT;
  - bit k is held during cycles k·CLK_PER_BIT+1 .. (k+1)·CLK_PER_BIT.
- Word duration: DBIT·CLK_PER_BIT busy cycles (plus CLK_PER_BIT with parity).
- Return to idle: `ready` goes high on the cycle after `done_tick`.
- Back-to-back words: minimum gap of one IDLE cycle between a word's last bit and the next word's first bit.
- CLK_PER_BIT = 1: `sout_en` is high on every busy cycle, and `sout` changes every cycle.
- `sout` and `sout_en` come from the same state register, so they change on the same edge. The downstream flop therefore samples a stable `sout`.

## Configuration
- SERIAL_BIT_TX_PARITY_EN defined:
  - even parity of `din` is computed and registered at accept;
  - after DATA, the FSM enters PARITY for CLK_PER_BIT cycles with `sout` = parity bit and `sout_en` on the last cycle;
  - `done_tick` moves to that parity strobe cycle.
- Undefined: no PARITY state and no parity register; DATA returns directly to IDLE.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> outputs immediately `ready` = 1, `sout` = 0, `sout_en` = 0, `done_tick` = 0.
- DBIT = 8, CLK_PER_BIT = 4, `din` = 8'hA5, one-cycle `start` -> `sout` sequence 1,0,1,0,0,1,0,1, each held 4 cycles. Eight `sout_en` pulses at cycles 4, 8, …, 32. `done_tick` at cycle 32; `ready` high at cycle 33.
- Capture check: connect outputs to an enable-gated capture flop plus an 8-bit shift register in the bench -> captured word equals 8'hA5; exactly 8 enables per word.
- Busy request: pulse `start` with `din` = 8'hFF at cycle 10 of an 8'h3C transfer -> ignored; transmitted bits are 0,0,1,1,1,1,0,0 and no second word follows.
- Back-to-back: hold `start` high for 8'h01 then 8'h80 -> the second word begins one IDLE cycle after the first `done_tick`; both words are captured correctly.
- Mid-word reset: assert `reset` at cycle 13 of 8'hF0 -> no further `sout_en`; no `done_tick`; `ready` = 1. With SERIAL_BIT_TX_PARITY_EN, `din` = 8'h07 -> ninth bit = 1 and `done_tick` at cycle 36.

Source files
------------

// File: rtl/serial_bit_tx.sv
`default_nettype none
// ============================================================================
// serial_bit_tx : MSB-first parallel-to-serial transmitter with a capture
// strobe for d+en downstream flops. Define SERIAL_BIT_TX_PARITY_EN to append
// an even-parity bit.                                         Revision: 1.0
// ============================================================================
module serial_bit_tx #(
  parameter int DBIT        = 8,
  parameter int CLK_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DBIT-1:0] din,
  output logic            ready,
  output logic            sout,
  output logic            sout_en,
  output logic            done_tick
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BW = (DBIT > 1) ? $clog2(DBIT + 1) : 1;
  localparam logic [CW-1:0] C_CYC_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(DBIT - 1);

`ifdef SERIAL_BIT_TX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;
  logic par_q, par_d;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            cyc_last;

  assign cyc_last = (cyc_q == C_CYC_LAST);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
`ifdef SERIAL_BIT_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = din;
          cyc_d   = '0;
          bit_d   = '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
          par_d   = ^din;
`endif
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d = '0;
          sh_d  = sh_q << 1;
          bit_d = bit_q + BW'(1);
          if (bit_q == C_BIT_LAST) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_IDLE;
`endif
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      S_PARITY: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Outputs decode registered state only, so sout and sout_en move on the same edge.
  assign ready   = (state_q == S_IDLE);
  assign sout_en = (state_q != S_IDLE) && cyc_last;

`ifdef SERIAL_BIT_TX_PARITY_EN
  assign sout      = (state_q == S_DATA) ? sh_q[DBIT-1] : ((state_q == S_PARITY) && par_q);
  assign done_tick = (state_q == S_PARITY) && cyc_last;
`else
  assign sout      = (state_q == S_DATA) && sh_q[DBIT-1];
  assign done_tick = (state_q == S_DATA) && cyc_last && (bit_q == C_BIT_LAST);
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_tx.sv
`default_nettype none
// ============================================================================
// tb_serial_bit_tx : self-checking bench for serial_bit_tx against a
// cycle-count reference model and a downstream capture flop.   Revision: 1.0
// ============================================================================
module tb_serial_bit_tx;

  localparam int DBIT = 8;
  localparam int CPB  = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int NB = DBIT + 1;
`else
  localparam int NB = DBIT;
`endif
  localparam int TOTAL = NB * CPB;
  localparam logic [15:0] CMASK = 16'((1 << NB) - 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [DBIT-1:0] din = '0;
  logic            ready, sout, sout_en, done_tick;

  int ntests = 0;
  int nfail  = 0;

  serial_bit_tx #(.DBIT(DBIT), .CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .ready     (ready),
    .sout      (sout),
    .sout_en   (sout_en),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  // Downstream enable-gated capture flop feeding a shift register.
  logic [15:0] cap_sh = '0;
  logic [15:0] cap_q[$];
  int          en_total = 0;
  int          done_total = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_sh <= '0;
    end else begin
      if (sout_en) begin
        cap_sh   <= {cap_sh[14:0], sout};
        en_total <= en_total + 1;
        if (done_tick) cap_q.push_back({cap_sh[14:0], sout} & CMASK);
      end
      if (done_tick) done_total <= done_total + 1;
    end
  end

  // Reference model: a word is just "cycles elapsed since acceptance".
  logic            m_busy = 1'b0;
  int              m_t = 0;
  logic [DBIT-1:0] m_word = '0;

  task automatic model_edge(input logic s, input logic [DBIT-1:0] d);
    if (m_busy) begin
      m_t++;
      if (m_t > TOTAL) begin
        m_busy = 1'b0;
        m_t    = 0;
      end
    end else if (s) begin
      m_busy = 1'b1;
      m_t    = 1;
      m_word = d;
    end
  endtask

  function automatic logic [3:0] exp_out();
    int   k;
    logic b;
    if (!m_busy) return 4'b1000;
    k = (m_t - 1) / CPB;
    b = (k < DBIT) ? m_word[DBIT-1-k] : ^m_word;
    return {1'b0, b, (m_t % CPB) == 0, m_t == TOTAL};
  endfunction

  function automatic logic [15:0] exp_cap(input logic [DBIT-1:0] w);
`ifdef SERIAL_BIT_TX_PARITY_EN
    return {7'd0, w, ^w};
`else
    return {8'd0, w};
`endif
  endfunction

  task automatic tick(input logic s, input logic [DBIT-1:0] d);
    start = s;
    din   = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_busy = 1'b0;
    m_t    = 0;
    start  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ntests++;
    if ({ready, sout, sout_en, done_tick} !== 4'b1000) begin
      nfail++;
      $display("FAIL reset_values: got %b want 1000", {ready, sout, sout_en, done_tick});
    end
    tick(1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00);
    #3;
    reset  = 1'b1;
    m_busy = 1'b0;
    #1;
    ntests++;
    if ({ready, sout, sout_en, done_tick} !== 4'b1000) begin
      nfail++;
      $display("FAIL async_reset: got %b want 1000", {ready, sout, sout_en, done_tick});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cap_q.delete();
  endtask

  task automatic test_a5();
    int en0, done_at, n0;
    en0 = en_total; done_at = -1; n0 = cap_q.size();
    tick(1'b1, 8'hA5);
    for (int i = 1; i <= TOTAL + 2; i++) begin
      tick(1'b0, $urandom);
      ntests++;
      if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
        nfail++;
        $display("FAIL a5_cycle t=%0d: got %b want %b", i + 1, {ready, sout, sout_en, done_tick}, exp_out());
      end
      if (done_tick) done_at = i;
      if (i == TOTAL) begin
        ntests++;
        if (ready !== 1'b1) begin
          nfail++;
          $display("FAIL a5_ready_after_done: got %b want 1", ready);
        end
      end
    end
    ntests++;
    if (done_at !== TOTAL - 1) begin
      nfail++;
      $display("FAIL a5_done_cycle: got %0d want %0d", done_at + 1, TOTAL);
    end
    ntests++;
    if (en_total - en0 !== NB) begin
      nfail++;
      $display("FAIL a5_enable_count: got %0d want %0d", en_total - en0, NB);
    end
    ntests++;
    if (cap_q.size() != n0 + 1 || cap_q[cap_q.size() - 1] !== exp_cap(8'hA5)) begin
      nfail++;
      $display("FAIL a5_capture: got %h want %h", (cap_q.size() > 0) ? cap_q[cap_q.size() - 1] : 16'hxxxx, exp_cap(8'hA5));
    end
  endtask

  task automatic test_random();
    logic [DBIT-1:0] sent[$];
    logic [DBIT-1:0] w;
    int n0;
    n0 = cap_q.size();
    for (int n = 0; n < 8; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tick(1'b0, $urandom);
        ntests++;
        if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
          nfail++;
          $display("FAIL random_gap w=%0d: got %b want %b", n, {ready, sout, sout_en, done_tick}, exp_out());
        end
      end
      w = DBIT'($urandom);
      sent.push_back(w);
      tick(1'b1, w);
      for (int c = 0; c < TOTAL; c++) begin
        tick(1'($urandom_range(0, 1)), DBIT'($urandom));
        ntests++;
        if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
          nfail++;
          $display("FAIL random_word %0d t=%0d: got %b want %b", n, c + 2, {ready, sout, sout_en, done_tick}, exp_out());
        end
      end
      start = 1'b0;
    end
    for (int n = 0; n < 8; n++) begin
      ntests++;
      if (cap_q.size() <= n0 + n || cap_q[n0 + n] !== exp_cap(sent[n])) begin
        nfail++;
        $display("FAIL random_capture %0d: got %h want %h", n, (cap_q.size() > n0 + n) ? cap_q[n0 + n] : 16'hxxxx, exp_cap(sent[n]));
      end
    end
  endtask

  task automatic test_busy_ignored();
    int n0, d0;
    n0 = cap_q.size(); d0 = done_total;
    tick(1'b1, 8'h3C);
    for (int i = 1; i <= TOTAL + 8; i++) begin
      tick(i == 10, (i == 10) ? 8'hFF : 8'h00);
      ntests++;
      if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
        nfail++;
        $display("FAIL busy_cycle t=%0d: got %b want %b", i + 1, {ready, sout, sout_en, done_tick}, exp_out());
      end
    end
    ntests++;
    if (cap_q.size() != n0 + 1 || done_total - d0 != 1 || cap_q[cap_q.size() - 1] !== exp_cap(8'h3C)) begin
      nfail++;
      $display("FAIL busy_capture: got %0d words, last %h want 1 word %h", cap_q.size() - n0, (cap_q.size() > 0) ? cap_q[cap_q.size() - 1] : 16'hxxxx, exp_cap(8'h3C));
    end
  endtask

  task automatic test_back_to_back();
    int n0, d1, d2, r;
    n0 = cap_q.size(); d1 = -1; d2 = -1; r = -1;
    tick(1'b1, 8'h01);
    for (int i = 1; i <= 2 * TOTAL + 3; i++) begin
      tick(i <= TOTAL + 1, 8'h80);
      ntests++;
      if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
        nfail++;
        $display("FAIL b2b_cycle i=%0d: got %b want %b", i, {ready, sout, sout_en, done_tick}, exp_out());
      end
      if (done_tick) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
      end
      if (d1 >= 0 && r < 0 && i > d1 && !ready) r = i;
    end
    ntests++;
    if (d1 != TOTAL - 1 || d2 != 2 * TOTAL || r - d1 != 2) begin
      nfail++;
      $display("FAIL b2b_timing: done at %0d,%0d restart %0d want %0d,%0d restart %0d", d1, d2, r, TOTAL - 1, 2 * TOTAL, TOTAL + 1);
    end
    ntests++;
    if (cap_q.size() != n0 + 2 || cap_q[n0] !== exp_cap(8'h01) || cap_q[n0 + 1] !== exp_cap(8'h80)) begin
      nfail++;
      $display("FAIL b2b_capture: got %0d words want 2 (%h,%h)", cap_q.size() - n0, exp_cap(8'h01), exp_cap(8'h80));
    end
  endtask

  task automatic test_midword_reset();
    int n0, e0, d0;
    tick(1'b1, 8'hF0);
    for (int i = 1; i <= 12; i++) tick(1'b0, 8'h00);
    #3;
    reset  = 1'b1;
    m_busy = 1'b0;
    m_t    = 0;
    #1;
    ntests++;
    if ({ready, sout, sout_en, done_tick} !== 4'b1000) begin
      nfail++;
      $display("FAIL midreset_outputs: got %b want 1000", {ready, sout, sout_en, done_tick});
    end
    n0 = cap_q.size(); e0 = en_total; d0 = done_total;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < TOTAL + 8; i++) begin
      tick(1'b0, $urandom);
      ntests++;
      if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
        nfail++;
        $display("FAIL midreset_idle i=%0d: got %b want %b", i, {ready, sout, sout_en, done_tick}, exp_out());
      end
    end
    ntests++;
    if (en_total != e0 || done_total != d0 || cap_q.size() != n0) begin
      nfail++;
      $display("FAIL midreset_activity: got %0d en %0d done want 0 0", en_total - e0, done_total - d0);
    end
  endtask

`ifdef SERIAL_BIT_TX_PARITY_EN
  task automatic test_parity();
    int n0, done_at;
    n0 = cap_q.size(); done_at = -1;
    tick(1'b1, 8'h07);
    for (int i = 1; i <= TOTAL + 2; i++) begin
      tick(1'b0, 8'h00);
      ntests++;
      if ({ready, sout, sout_en, done_tick} !== exp_out()) begin
        nfail++;
        $display("FAIL parity_cycle t=%0d: got %b want %b", i + 1, {ready, sout, sout_en, done_tick}, exp_out());
      end
      if (done_tick) done_at = i + 1;
    end
    ntests++;
    if (done_at != 36 || cap_q.size() != n0 + 1 || cap_q[n0] !== 16'h000F) begin
      nfail++;
      $display("FAIL parity_word: done at %0d capture %h want 36 000f", done_at, (cap_q.size() > n0) ? cap_q[n0] : 16'hxxxx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_a5();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    test_midword_reset();
`ifdef SERIAL_BIT_TX_PARITY_EN
    test_parity();
`endif
    do_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
